adsr_envelope: RTL and testbench



---
 rtl/adsr_envelope_if.sv | 25 ++
 rtl/adsr_envelope.sv | 134 +++++++++++++
 tb/tb_adsr_envelope.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/adsr_envelope_if.sv
// Signal-path bundle for the ADSR amplitude stage: note gate and summed
// waveform in, enveloped signal and envelope status out.
interface adsr_envelope_if;
    logic        gate;
    logic [15:0] sig_in;
    logic [15:0] sig_out;
    logic [15:0] env;
    logic        env_active;

    modport master (
        output gate,
        output sig_in,
        input  sig_out,
        input  env,
        input  env_active
    );

    modport slave (
        input  gate,
        input  sig_in,
        output sig_out,
        output env,
        output env_active
    );
endinterface

// File: rtl/adsr_envelope.sv
// ADSR envelope generator and amplitude scaler: shapes the summed waveform
// with a tick-driven attack/decay/sustain/release level.
module adsr_envelope #(
    parameter int unsigned TICK_DIV      = 1000,
    parameter logic [15:0] ATTACK_STEP   = 16'h0100,
    parameter logic [15:0] DECAY_STEP    = 16'h0040,
    parameter logic [15:0] SUSTAIN_LEVEL = 16'hC000,
    parameter logic [15:0] RELEASE_STEP  = 16'h0080
) (
    input  logic           clk,
    input  logic           rst_n,
    adsr_envelope_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ATTACK,
        S_DECAY,
        S_SUSTAIN,
        S_RELEASE
    } state_t;

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

    logic [1:0]  sync_q;
    logic        gate_s;
    logic [15:0] cnt_q;
    logic        tick;
    state_t      state_q, state_d;
    logic [15:0] env_q, env_d;
    logic [16:0] att_sum, dec_diff, rel_diff;
    logic [15:0] sig_out_q;
    logic        env_active_q;

    // The gate comes straight from a button; only the second flop is trusted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[0], bus.gate};
    end
    assign gate_s = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    cnt_q <= '0;
        else if (tick) cnt_q <= '0;
        else           cnt_q <= cnt_q + 16'd1;
    end
    assign tick = (cnt_q == TICK_LAST);

    assign att_sum  = {1'b0, env_q} + {1'b0, ATTACK_STEP};
    assign dec_diff = {1'b0, env_q} - {1'b0, DECAY_STEP};
    assign rel_diff = {1'b0, env_q} - {1'b0, RELEASE_STEP};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            env_q   <= '0;
        end else begin
            state_q <= state_d;
            env_q   <= env_d;
        end
    end

    // Gate-driven transitions win over level steps; a tick coinciding with
    // one is simply skipped.
    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        case (state_q)
            S_IDLE: begin
                env_d = '0;
                if (gate_s) state_d = S_ATTACK;
            end
            S_ATTACK: begin
                if (!gate_s) begin
                    state_d = S_RELEASE;
                end else if (tick) begin
                    if (att_sum[16]) begin
                        env_d   = 16'hFFFF;
                        state_d = S_DECAY;
                    end else begin
                        env_d = att_sum[15:0];
                    end
                end
            end
            S_DECAY: begin
                if (!gate_s) begin
                    state_d = S_RELEASE;
                end else if (tick) begin
                    if (dec_diff[16] || dec_diff[15:0] <= SUSTAIN_LEVEL) begin
                        env_d   = SUSTAIN_LEVEL;
                        state_d = S_SUSTAIN;
                    end else begin
                        env_d = dec_diff[15:0];
                    end
                end
            end
            S_SUSTAIN: begin
                if (!gate_s) state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (gate_s) begin
                    state_d = S_ATTACK;
                end else if (tick) begin
                    if (env_q <= RELEASE_STEP) begin
                        env_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        env_d = rel_diff[15:0];
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                env_d   = '0;
            end
        endcase
    end

    // Upper half of the 16x16 product keeps full scale at env=0xFFFF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_out_q    <= '0;
            env_active_q <= 1'b0;
        end else begin
            sig_out_q    <= 16'((32'(bus.sig_in) * 32'(env_q)) >> 16);
            env_active_q <= (state_d != S_IDLE);
        end
    end

    assign bus.sig_out    = sig_out_q;
    assign bus.env        = env_q;
    assign bus.env_active = env_active_q;

endmodule

// File: tb/tb_adsr_envelope.sv
// Scoreboard bench: a behavioural envelope model predicts each cycle's
// outputs for two configurations (TICK_DIV=4 and TICK_DIV=1).
module tb_adsr_envelope;

    logic        clk;
    logic        rst_n;
    logic        gate;
    logic [15:0] sig_in;

    int vectors;
    int miscompares;

    adsr_envelope_if if0 ();
    adsr_envelope_if if1 ();
    assign if0.gate   = gate;
    assign if0.sig_in = sig_in;
    assign if1.gate   = gate;
    assign if1.sig_in = sig_in;

    adsr_envelope #(
        .TICK_DIV(4), .ATTACK_STEP(16'h4000), .DECAY_STEP(16'h1000),
        .SUSTAIN_LEVEL(16'hC000), .RELEASE_STEP(16'h4000)
    ) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));

    adsr_envelope #(
        .TICK_DIV(1), .ATTACK_STEP(16'h4000), .DECAY_STEP(16'h1000),
        .SUSTAIN_LEVEL(16'hC000), .RELEASE_STEP(16'h4000)
    ) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    localparam int P_IDLE = 0, P_ATT = 1, P_DEC = 2, P_SUS = 3, P_REL = 4;
    localparam int ASTEP = 16'h4000, DSTEP = 16'h1000, SUS = 16'hC000, RSTEP = 16'h4000;

    typedef struct {
        int lvl;
        int out;
        int act;
    } exp_t;

    int   phase [2];
    int   level [2];
    int   ticks [2];   // cycles since the last tick
    int   period[2];
    logic gate_seen[2]; // gate as delayed by the synchronizer (0 = newest)
    exp_t q0[$];
    exp_t q1[$];

    function automatic exp_t step(int i, logic gs, logic [15:0] din);
        exp_t r;
        bit   tk;
        r.out = int'((longint'(din) * longint'(level[i])) >>> 16);
        tk = (ticks[i] == period[i] - 1);
        ticks[i] = tk ? 0 : ticks[i] + 1;
        if ((phase[i] == P_IDLE || phase[i] == P_REL) && gs) begin
            phase[i] = P_ATT;
        end else if ((phase[i] == P_ATT || phase[i] == P_DEC || phase[i] == P_SUS) && !gs) begin
            phase[i] = P_REL;
        end else if (tk) begin
            if (phase[i] == P_ATT) begin
                level[i] += ASTEP;
                if (level[i] >= 65536) begin level[i] = 65535; phase[i] = P_DEC; end
            end else if (phase[i] == P_DEC) begin
                if (level[i] - DSTEP <= SUS) begin level[i] = SUS; phase[i] = P_SUS; end
                else level[i] -= DSTEP;
            end else if (phase[i] == P_REL) begin
                if (level[i] <= RSTEP) begin level[i] = 0; phase[i] = P_IDLE; end
                else level[i] -= RSTEP;
            end
        end
        r.lvl = level[i];
        r.act = (phase[i] != P_IDLE) ? 1 : 0;
        return r;
    endfunction

    always @(posedge clk) begin
        exp_t e0, e1;
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                phase[i] = P_IDLE; level[i] = 0; ticks[i] = 0;
            end
            gate_seen[0] = 1'b0; gate_seen[1] = 1'b0;
            e0.lvl = 0; e0.out = 0; e0.act = 0;
            q0.push_back(e0);
            q1.push_back(e0);
        end else begin
            e0 = step(0, gate_seen[1], sig_in);
            e1 = step(1, gate_seen[1], sig_in);
            q0.push_back(e0);
            q1.push_back(e1);
            gate_seen[1] = gate_seen[0];
            gate_seen[0] = gate;
        end
    end

    // ---------------- monitor ----------------
    task automatic chk(string nm, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (q0.size() > 0) begin
            e = q0.pop_front();
            chk("div4.env", int'(if0.env), e.lvl);
            chk("div4.sig_out", int'(if0.sig_out), e.out);
            chk("div4.env_active", int'(if0.env_active), e.act);
        end
        while (q1.size() > 0) begin
            e = q1.pop_front();
            chk("div1.env", int'(if1.env), e.lvl);
            chk("div1.sig_out", int'(if1.sig_out), e.out);
            chk("div1.env_active", int'(if1.env_active), e.act);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic async_reset_check();
        rst_n = 1'b0;
        #1;
        chk("async_rst.env", int'(if0.env), 0);
        chk("async_rst.sig_out", int'(if0.sig_out), 0);
        chk("async_rst.env_active", int'(if0.env_active), 0);
        chk("async_rst1.env", int'(if1.env), 0);
    endtask

    initial begin
        period[0] = 4;
        period[1] = 1;
        vectors = 0;
        miscompares = 0;
        rst_n  = 1'b0;
        gate   = 1'b1;
        sig_in = 16'hFFFF;
        cyc(4);
        gate  = 1'b0;
        rst_n = 1'b1;
        cyc(3);

        // attack to saturation, decay, sustain with scaling probes
        gate = 1'b1;
        sig_in = 16'h8000;
        cyc(70);
        for (int k = 0; k < 6; k++) begin
            sig_in = 16'($urandom);
            cyc(1);
        end
        sig_in = 16'h8000;
        cyc(2);

        // release, retrigger mid-release, release to idle
        gate = 1'b0;
        cyc(6);
        gate = 1'b1;
        cyc(12);
        gate = 1'b0;
        cyc(50);

        // one-clock glitch from idle
        gate = 1'b1;
        cyc(1);
        gate = 1'b0;
        cyc(30);

        // gate fall swept across every tick phase during attack
        for (int k = 0; k < 4; k++) begin
            gate = 1'b1;
            cyc(6 + k);
            gate = 1'b0;
            cyc(40);
        end

        // reset asserted mid-release
        gate = 1'b1;
        cyc(50);
        gate = 1'b0;
        cyc(6);
        async_reset_check();
        cyc(3);
        rst_n = 1'b1;
        cyc(5);

        // randomized gate activity and signal
        for (int k = 0; k < 1500; k++) begin
            sig_in = 16'($urandom);
            if ($urandom_range(0, 24) == 0) gate = ~gate;
            cyc(1);
        end
        gate = 1'b0;
        cyc(3);
        chk("drain.q0", q0.size(), 0);
        chk("drain.q1", q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
